// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared constants and FSM state type for the Wu-Manber window feeder
package wm_pkg;

   localparam int WM_WIN_BYTES     = 20;
   localparam int WM_OVERLAP_BYTES = 9;
   localparam int WM_HOLD_CYCLES   = 84;

   typedef enum logic [2:0] {
      FILL,
      ISSUE,
      SCAN,
      REPORT,
      SLIDE
   } wm_feed_state_t;

endpackage

// File: rtl/wm_win_buffer.sv
// rtl/wm_win_buffer.sv - window lane register: write-at-index, slide by the non-overlapping span, clear
module wm_win_buffer
   import wm_pkg::*;
#(
   parameter int WIN_BYTES     = WM_WIN_BYTES,
   parameter int OVERLAP_BYTES = WM_OVERLAP_BYTES,
   localparam int CW           = $clog2(WIN_BYTES + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_en_i,
   input  logic [CW-1:0]          wr_idx_i,
   input  logic [7:0]             wr_byte_i,
   input  logic                   slide_i,
   input  logic                   clear_i,
   output logic [8*WIN_BYTES-1:0] din_o
);

   localparam int SHIFT = WIN_BYTES - OVERLAP_BYTES;

   logic [8*WIN_BYTES-1:0] lanes_q;
   logic [8*WIN_BYTES-1:0] lanes_d;

   // Lane k lives at bits [8k+7:8k], so a right shift by SHIFT bytes moves the tail
   // lanes down to lane 0 and zero-fills everything above the overlap.
   always_comb begin
      lanes_d = lanes_q;
      if (clear_i) begin
         lanes_d = '0;
      end else if (slide_i) begin
         lanes_d = lanes_q >> (8 * SHIFT);
      end else if (wr_en_i) begin
         for (int k = 0; k < WIN_BYTES; k++) begin
            if (wr_idx_i == CW'(k)) begin
               lanes_d[8*k +: 8] = wr_byte_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lanes_q <= '0;
      end else begin
         lanes_q <= lanes_d;
      end
   end

   assign din_o = lanes_q;

endmodule

// File: rtl/wm_window_feeder.sv
// rtl/wm_window_feeder.sv - packs a byte stream into overlapping windows, holds each for the
// worker scan budget and reports whether the worker flagged a match
module wm_window_feeder
   import wm_pkg::*;
#(
   parameter int WIN_BYTES     = WM_WIN_BYTES,
   parameter int OVERLAP_BYTES = WM_OVERLAP_BYTES,
   parameter int HOLD_CYCLES   = WM_HOLD_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valid,
   input  logic                   byte_last,
   output logic                   byte_ready,
   output logic [8*WIN_BYTES-1:0] din,
   output logic                   datInReady,
   input  logic                   rom_out,
   output logic                   match_valid,
   output logic                   match_hit,
   output logic [15:0]            match_win,
   output logic                   pkt_done
);

   localparam int CW = $clog2(WIN_BYTES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   wm_feed_state_t state_q;
   logic [CW-1:0]  cnt_q;
   logic [HW-1:0]  hold_q;
   logic           hit_q;
   logic           last_q;
   logic           ready_q;
   logic           dat_rdy_q;
   logic           mvalid_q;
   logic           mhit_q;
   logic [15:0]    mwin_q;
   logic           pkt_done_q;
   logic [15:0]    win_idx_q;
   logic [15:0]    win_idx_d;
   logic           accept;

   // ready_q is only ever set while in FILL, so it doubles as the acceptance qualifier
   assign accept = ready_q & byte_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FILL;
         cnt_q      <= '0;
         hold_q     <= '0;
         hit_q      <= 1'b0;
         last_q     <= 1'b0;
         ready_q    <= 1'b0;
         dat_rdy_q  <= 1'b0;
         mvalid_q   <= 1'b0;
         mhit_q     <= 1'b0;
         mwin_q     <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         dat_rdy_q  <= 1'b0;
         mvalid_q   <= 1'b0;
         mhit_q     <= 1'b0;
         mwin_q     <= '0;
         pkt_done_q <= 1'b0;
         case (state_q)
            FILL: begin
               ready_q <= 1'b1;
               if (accept) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (byte_last) begin
                     last_q <= 1'b1;
                  end
                  if (byte_last || cnt_q == CW'(WIN_BYTES - 1)) begin
                     state_q   <= ISSUE;
                     ready_q   <= 1'b0;
                     dat_rdy_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               hit_q   <= 1'b0;
               hold_q  <= HW'(HOLD_CYCLES);
               state_q <= SCAN;
            end
            SCAN: begin
               hit_q  <= hit_q | rom_out;
               hold_q <= hold_q - HW'(1);
               // Last hold cycle: fold in this cycle's rom_out directly into the report
               if (hold_q == HW'(1)) begin
                  state_q    <= REPORT;
                  mvalid_q   <= 1'b1;
                  mhit_q     <= hit_q | rom_out;
                  mwin_q     <= win_idx_q;
                  pkt_done_q <= last_q;
               end
            end
            REPORT: begin
               state_q <= SLIDE;
            end
            SLIDE: begin
               cnt_q   <= last_q ? CW'(0) : CW'(OVERLAP_BYTES);
               last_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= FILL;
            end
            default: begin
               state_q <= FILL;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      win_idx_d = win_idx_q;
      if (state_q == SLIDE) begin
         win_idx_d = last_q ? 16'd0 : win_idx_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_idx_q <= '0;
      end else begin
         win_idx_q <= win_idx_d;
      end
   end

   wm_win_buffer #(
      .WIN_BYTES    (WIN_BYTES),
      .OVERLAP_BYTES(OVERLAP_BYTES)
   ) u_buf (
      .clk_i    (clk),
      .rst_ni   (rst),
      .wr_en_i  (accept),
      .wr_idx_i (cnt_q),
      .wr_byte_i(byte_in),
      .slide_i  ((state_q == SLIDE) && !last_q),
      .clear_i  ((state_q == SLIDE) && last_q),
      .din_o    (din)
   );

   assign byte_ready  = ready_q;
   assign datInReady  = dat_rdy_q;
   assign match_valid = mvalid_q;
   assign match_hit   = mhit_q;
   assign match_win   = mwin_q;
   assign pkt_done    = pkt_done_q;

endmodule

// File: tb/tb_wm_window_feeder.sv
// tb/tb_wm_window_feeder.sv - directed self-checking bench for wm_window_feeder with a stub worker
module tb_wm_window_feeder;

   localparam int WIN   = 20;
   localparam int SHIFT = 11;
   localparam int HOLD  = 84;

   typedef struct {
      logic [159:0] din;
      int           cyc;
      int           lat;
   } win_rec_t;

   typedef struct {
      logic        hit;
      logic [15:0] win;
      logic        done;
      int          cyc;
   } rep_rec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [7:0]   byte_in = '0;
   logic         byte_valid = 1'b0;
   logic         byte_last = 1'b0;
   logic         byte_ready;
   logic [159:0] din;
   logic         datInReady;
   logic         rom_out = 1'b0;
   logic         match_valid;
   logic         match_hit;
   logic [15:0]  match_win;
   logic         pkt_done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   int since_issue = -1;
   int pulse_at = 0;
   int run = 0;
   int idle_viol = 0;

   logic [7:0] acc_q[$];
   win_rec_t   win_q[$];
   rep_rec_t   rep_q[$];
   int         runs_q[$];

   wm_window_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .din        (din),
      .datInReady (datInReady),
      .rom_out    (rom_out),
      .match_valid(match_valid),
      .match_hit  (match_hit),
      .match_win  (match_win),
      .pkt_done   (pkt_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor and stub worker: everything sampled mid-cycle, away from the rising edge
   always @(negedge clk) begin
      if (!rst) begin
         since_issue = -1;
         rom_out     = 1'b0;
         run         = 0;
      end else begin
         if (byte_valid && byte_ready) begin
            acc_q.push_back(byte_in);
            last_acc_cyc = cyc;
         end
         if (datInReady) begin
            win_rec_t w;
            w.din = din;
            w.cyc = cyc;
            w.lat = cyc - last_acc_cyc;
            win_q.push_back(w);
            since_issue = 0;
         end else if (since_issue >= 0) begin
            since_issue++;
         end
         rom_out = (pulse_at > 0) && (since_issue == pulse_at);
         if (match_valid) begin
            rep_rec_t r;
            r.hit  = match_hit;
            r.win  = match_win;
            r.done = pkt_done;
            r.cyc  = cyc;
            rep_q.push_back(r);
         end else if (match_hit || match_win != 16'd0 || pkt_done) begin
            idle_viol++;
         end
         if (!byte_ready) begin
            run++;
         end else if (run > 0) begin
            runs_q.push_back(run);
            run = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      acc_q.delete();
      win_q.delete();
      rep_q.delete();
      runs_q.delete();
   endtask

   task automatic send_packet(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         int g;
         byte_in    = base + 8'(i);
         byte_valid = 1'b1;
         byte_last  = (i == n - 1);
         g = 0;
         while (!byte_ready && g < 500) begin
            step();
            g++;
         end
         if (g >= 500) begin
            chk("ready_timeout", 160'(g), 160'(0));
            break;
         end
         step();
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic check_packet(input int n, input logic [7:0] base, input logic [15:0] first_win,
                               input logic exp_hit);
      int           nw;
      int           start;
      int           g;
      int           errs;
      logic [159:0] exp_din;
      logic [15:0]  ew;
      nw    = 1;
      start = 0;
      while (start + WIN < n) begin
         start += SHIFT;
         nw++;
      end
      g = 0;
      while (rep_q.size() < nw && g < 400 * nw) begin
         step();
         g++;
      end
      repeat (4) step();
      chk("report_count", 160'(rep_q.size()), 160'(nw));
      chk("window_count", 160'(win_q.size()), 160'(nw));
      start = 0;
      for (int w = 0; w < nw; w++) begin
         exp_din = '0;
         for (int k = 0; k < WIN; k++) begin
            if (start + k < n) exp_din[8*k +: 8] = base + 8'(start + k);
         end
         ew = first_win + 16'(w);
         if (w < win_q.size()) begin
            chk("window_din", win_q[w].din, exp_din);
            chk("issue_latency", 160'(win_q[w].lat), 160'(1));
         end
         if (w < rep_q.size()) begin
            chk("report_win", 160'(rep_q[w].win), 160'(ew));
            chk("report_hit", 160'(rep_q[w].hit), 160'(exp_hit));
            chk("report_pkt_done", 160'(rep_q[w].done), 160'(w == nw - 1));
            if (w < win_q.size())
               chk("report_latency", 160'(rep_q[w].cyc - win_q[w].cyc), 160'(HOLD + 1));
         end
         start += SHIFT;
      end
      chk("stream_len", 160'(acc_q.size()), 160'(n));
      errs = 0;
      for (int i = 0; i < acc_q.size(); i++) begin
         if (acc_q[i] !== base + 8'(i)) errs++;
      end
      chk("stream_bytes", 160'(errs), 160'(0));
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("reset_din", din, '0);
      chk("reset_ctl", 160'({byte_ready, datInReady, match_valid, match_hit, match_win, pkt_done}), '0);
      rst = 1'b1;
      step();
      chk("ready_after_reset", 160'(byte_ready), 160'(1));

      // Full window closed by byte_last on the final lane
      clear_logs();
      send_packet(20, 8'h00);
      check_packet(20, 8'h00, 16'h0000, 1'b0);
      if (win_q.size() > 0) begin
         chk("full_lane0", 160'(win_q[0].din[7:0]), 160'(8'h00));
         chk("full_lane19", 160'(win_q[0].din[159:152]), 160'(8'h13));
      end

      // Overlap, zero padding and backpressure with byte_valid held high
      clear_logs();
      send_packet(29, 8'h00);
      check_packet(29, 8'h00, 16'h0000, 1'b0);
      if (win_q.size() > 1) begin
         chk("ovl_lane0", 160'(win_q[1].din[7:0]), 160'(8'h0B));
         chk("ovl_lane17", 160'(win_q[1].din[143:136]), 160'(8'h1C));
         chk("ovl_pad", 160'(win_q[1].din[159:144]), 160'(16'h0000));
      end
      chk("ready_low_runs", 160'(runs_q.size()), 160'(2));
      if (runs_q.size() > 1) begin
         chk("ready_low_len0", 160'(runs_q[0]), 160'(87));
         chk("ready_low_len1", 160'(runs_q[1]), 160'(87));
      end

      // Hit capture: last SCAN cycle, REPORT cycle (ignored), first SCAN cycle
      clear_logs();
      pulse_at = 84;
      send_packet(3, 8'h80);
      check_packet(3, 8'h80, 16'h0000, 1'b1);
      clear_logs();
      pulse_at = 85;
      send_packet(3, 8'h90);
      check_packet(3, 8'h90, 16'h0000, 1'b0);
      clear_logs();
      pulse_at = 1;
      send_packet(3, 8'hC0);
      check_packet(3, 8'hC0, 16'h0000, 1'b1);
      pulse_at = 0;

      // Reset asserted on SCAN cycle 10 of a window
      clear_logs();
      send_packet(5, 8'h40);
      repeat (10) step();
      rst = 1'b0;
      #1;
      chk("midscan_din", din, '0);
      chk("midscan_ctl", 160'({byte_ready, datInReady, match_valid, match_hit, match_win, pkt_done}), '0);
      repeat (3) step();
      rst = 1'b1;
      repeat (120) step();
      chk("midscan_no_report", 160'(rep_q.size()), 160'(0));
      clear_logs();
      send_packet(3, 8'h60);
      check_packet(3, 8'h60, 16'h0000, 1'b0);

      // Window index wrap on a 31-byte packet: two full windows, no trailing window
      clear_logs();
      force dut.win_idx_q = 16'hFFFF;
      step();
      release dut.win_idx_q;
      send_packet(31, 8'hA0);
      check_packet(31, 8'hA0, 16'hFFFF, 1'b0);

      chk("idle_report_zero", 160'(idle_viol), 160'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
